// File: rtl/cpu_reg_file_dumper_if.sv
// Register-file access port plus dump/load streams seen by the debug dumper.
// master = the dumper; slave = register file, arbiter and stream endpoints.
interface cpu_reg_file_dumper_if #(
  parameter int unsigned BITS = 8,
  parameter int unsigned SIZE = 16
);
  localparam int unsigned ADDRESS_BITS = $clog2(SIZE);

  logic                    rf_req;
  logic                    rf_gnt;
  logic                    rf_en;
  logic                    rf_wr;
  logic [ADDRESS_BITS-1:0] rf_addr_read_1;
  logic [ADDRESS_BITS-1:0] rf_addr_read_2;
  logic [ADDRESS_BITS-1:0] rf_addr_write;
  logic [BITS-1:0]         rf_data_read_1;
  logic [BITS-1:0]         rf_data_read_2;
  logic [BITS-1:0]         rf_data_write;
  logic                    out_valid;
  logic                    out_ready;
  logic [BITS-1:0]         out_data;
  logic [ADDRESS_BITS-1:0] out_addr;
  logic                    in_valid;
  logic                    in_ready;
  logic [BITS-1:0]         in_data;

  modport master (
    output rf_req, rf_en, rf_wr, rf_addr_read_1, rf_addr_read_2, rf_addr_write, rf_data_write,
    input  rf_gnt, rf_data_read_1, rf_data_read_2,
    output out_valid, out_data, out_addr,
    input  out_ready,
    input  in_valid, in_data,
    output in_ready
  );

  modport slave (
    input  rf_req, rf_en, rf_wr, rf_addr_read_1, rf_addr_read_2, rf_addr_write, rf_data_write,
    output rf_gnt, rf_data_read_1, rf_data_read_2,
    input  out_valid, out_data, out_addr,
    output out_ready,
    output in_valid, in_data,
    input  in_ready
  );
endinterface

// File: rtl/cpu_reg_file_dumper.sv
// Debug initiator: dumps every CPU register as a valid/ready stream (two reads
// per access) or loads every register from one (one write per accepted word).
module cpu_reg_file_dumper #(
  parameter int unsigned BITS = 8,
  parameter int unsigned SIZE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mode,
  output logic busy,
  output logic done,
  cpu_reg_file_dumper_if.master rf
);
  localparam int unsigned ADDRESS_BITS = $clog2(SIZE);
  localparam logic [ADDRESS_BITS-1:0] LAST_PAIR = ADDRESS_BITS'(SIZE - 2);
  localparam logic [ADDRESS_BITS-1:0] LAST_REG  = ADDRESS_BITS'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, REQ, RD, SEND_A, SEND_B, LOAD, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] idx_q, idx_d;
  logic                    mode_q, mode_d;
  logic [BITS-1:0]         data_a_q, data_a_d;
  logic [BITS-1:0]         data_b_q, data_b_d;
  logic [ADDRESS_BITS-1:0] idx_next;

  assign idx_next = idx_q + ADDRESS_BITS'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    mode_d            = mode_q;
    data_a_d          = data_a_q;
    data_b_d          = data_b_q;
    busy              = 1'b0;
    done              = 1'b0;
    rf.rf_req         = 1'b0;
    rf.rf_en          = 1'b0;
    rf.rf_wr          = 1'b0;
    rf.rf_addr_read_1 = '0;
    rf.rf_addr_read_2 = '0;
    rf.rf_addr_write  = '0;
    rf.rf_data_write  = '0;
    rf.out_valid      = 1'b0;
    rf.out_data       = '0;
    rf.out_addr       = '0;
    rf.in_ready       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          idx_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        busy      = 1'b1;
        rf.rf_req = 1'b1;
        if (rf.rf_gnt) state_d = mode_q ? LOAD : RD;
      end
      RD: begin
        busy              = 1'b1;
        rf.rf_req         = 1'b1;
        rf.rf_en          = rf.rf_gnt;
        rf.rf_addr_read_1 = idx_q;
        rf.rf_addr_read_2 = idx_next;
        // read data is only meaningful while granted, so capture only then
        if (rf.rf_gnt) begin
          data_a_d = rf.rf_data_read_1;
          data_b_d = rf.rf_data_read_2;
          state_d  = SEND_A;
        end
      end
      SEND_A: begin
        busy         = 1'b1;
        rf.rf_req    = 1'b1;
        rf.out_valid = 1'b1;
        rf.out_data  = data_a_q;
        rf.out_addr  = idx_q;
        if (rf.out_ready) state_d = SEND_B;
      end
      SEND_B: begin
        busy         = 1'b1;
        rf.rf_req    = 1'b1;
        rf.out_valid = 1'b1;
        rf.out_data  = data_b_q;
        rf.out_addr  = idx_next;
        if (rf.out_ready) begin
          if (idx_q == LAST_PAIR) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDRESS_BITS'(2);
            state_d = RD;
          end
        end
      end
      LOAD: begin
        busy             = 1'b1;
        rf.rf_req        = 1'b1;
        rf.in_ready      = rf.rf_gnt;
        rf.rf_en         = rf.rf_gnt & rf.in_valid;
        rf.rf_wr         = rf.rf_gnt & rf.in_valid;
        rf.rf_addr_write = idx_q;
        rf.rf_data_write = rf.in_data;
        if (rf.rf_gnt && rf.in_valid) begin
          if (idx_q == LAST_REG) state_d = DONE;
          else                   idx_d   = idx_next;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // outputs are quiet in a reset cycle so no register-file access can slip out
    if (rst) begin
      busy              = 1'b0;
      done              = 1'b0;
      rf.rf_req         = 1'b0;
      rf.rf_en          = 1'b0;
      rf.rf_wr          = 1'b0;
      rf.rf_addr_read_1 = '0;
      rf.rf_addr_read_2 = '0;
      rf.rf_addr_write  = '0;
      rf.rf_data_write  = '0;
      rf.out_valid      = 1'b0;
      rf.out_data       = '0;
      rf.out_addr       = '0;
      rf.in_ready       = 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_reg_file_dumper.sv
// Bench for cpu_reg_file_dumper: register-file model, arbiter grant and stream
// endpoints driven per scenario; expected words/writes queued and popped on handshake.
module tb_cpu_reg_file_dumper;
  localparam int unsigned BITS = 8;
  localparam int unsigned SIZE = 16;
  localparam int unsigned AW   = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic mode;
  logic busy;
  logic done;

  cpu_reg_file_dumper_if #(.BITS(BITS), .SIZE(SIZE)) bus ();

  cpu_reg_file_dumper #(.BITS(BITS), .SIZE(SIZE)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .rf    (bus.master)
  );

  always #5 clk = ~clk;

  logic [BITS-1:0] mem [SIZE];
  assign bus.rf_data_read_1 = bus.rf_en ? mem[bus.rf_addr_read_1] : 'x;
  assign bus.rf_data_read_2 = bus.rf_en ? mem[bus.rf_addr_read_2] : 'x;

  wire [38:0] all_outs = {busy, done, bus.rf_req, bus.rf_en, bus.rf_wr,
                          bus.rf_addr_read_1, bus.rf_addr_read_2, bus.rf_addr_write,
                          bus.rf_data_write, bus.out_valid, bus.out_data, bus.out_addr,
                          bus.in_ready};

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [BITS-1:0] data;
  } word_t;

  word_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    bus.rf_gnt = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL reset_outs: got %h want 0", all_outs); end
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL idle_outs: got %h want 0", all_outs); end
    @(posedge clk); #1;
  endtask

  // Runs one full dump; expected words are base+i at address i.
  task automatic dump_and_check(input logic [7:0] base, input bit toggle, input int gnt_rise,
                                input string tag);
    int c, words, done_cyc, first_cyc, rd_cyc;
    bit held;
    word_t held_w, w;
    exp_q.delete();
    for (int i = 0; i < int'(SIZE); i++) begin
      w.addr = AW'(i);
      w.data = 8'(base + 8'(i));
      exp_q.push_back(w);
    end
    rd_cyc = (gnt_rise > 1 ? gnt_rise : 1) + 1;
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    bus.rf_gnt = (gnt_rise == 0);
    start = 1'b1; mode = 1'b0;
    words = 0; done_cyc = -1; first_cyc = -1; held = 1'b0;
    for (c = 0; c < 200 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy c=%0d: got %b want 1", tag, c, busy); end
      end
      if (c == rd_cyc) begin
        total++;
        if (bus.rf_en !== 1'b1) begin bad++; $display("FAIL %s rd_entry c=%0d: rf_en got %b want 1", tag, c, bus.rf_en); end
      end
      if (!bus.rf_gnt && c >= 1 && words == 0) begin
        total++;
        if (bus.rf_req !== 1'b1 || bus.rf_en !== 1'b0)
          begin bad++; $display("FAIL %s wait_gnt c=%0d: req/en got %b%b want 10", tag, c, bus.rf_req, bus.rf_en); end
      end
      if (bus.rf_en === 1'b1) begin
        total++;
        if (bus.out_valid !== 1'b0 || bus.rf_wr !== 1'b0 || bus.rf_addr_read_1 !== AW'(words) ||
            bus.rf_addr_read_2 !== AW'(words + 1))
          begin bad++; $display("FAIL %s rd_access c=%0d: addr %0d/%0d valid %b wr %b want %0d/%0d 0 0",
                                tag, c, bus.rf_addr_read_1, bus.rf_addr_read_2, bus.out_valid, bus.rf_wr, words, words + 1); end
      end
      if (held) begin
        total++;
        if (bus.out_valid !== 1'b1 || {bus.out_addr, bus.out_data} !== held_w)
          begin bad++; $display("FAIL %s hold c=%0d: got %b %h want 1 %h", tag, c, bus.out_valid, {bus.out_addr, bus.out_data}, held_w); end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL %s extra_word c=%0d: got %h want none", tag, c, {bus.out_addr, bus.out_data});
        end else begin
          w = exp_q.pop_front();
          if ({bus.out_addr, bus.out_data} !== w)
            begin bad++; $display("FAIL %s word c=%0d: got %h want %h", tag, c, {bus.out_addr, bus.out_data}, w); end
        end
        words++;
        if (words == 1) first_cyc = c;
        held = 1'b0;
      end else if (bus.out_valid === 1'b1) begin
        held = 1'b1; held_w = {bus.out_addr, bus.out_data};
      end else begin
        held = 1'b0;
      end
      if (done === 1'b1) done_cyc = c;
      @(posedge clk); #1;
      start = 1'b0;
      if (c + 1 == gnt_rise) bus.rf_gnt = 1'b1;
      if (toggle) bus.out_ready = ~bus.out_ready;
    end
    total++;
    if (done_cyc < 0) begin bad++; $display("FAIL %s timeout: done got never want pulse", tag); end
    total++;
    if (words != int'(SIZE) || exp_q.size() != 0)
      begin bad++; $display("FAIL %s count: got %0d words (%0d left) want %0d", tag, words, exp_q.size(), SIZE); end
    if (!toggle) begin
      total++;
      if (first_cyc != rd_cyc + 1 || done_cyc != rd_cyc + 24)
        begin bad++; $display("FAIL %s latency: first %0d done %0d want %0d %0d", tag, first_cyc, done_cyc, rd_cyc + 1, rd_cyc + 24); end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL %s after_done: got %h want 0", tag, all_outs); end
    @(posedge clk); #1;
  endtask

  task automatic test_dump();
    for (int i = 0; i < int'(SIZE); i++) mem[i] = 8'(8'hA0 + 8'(i));
    dump_and_check(8'hA0, 1'b0, 0, "dump");
  endtask

  task automatic test_ready_toggle();
    dump_and_check(8'hA0, 1'b1, 0, "ready_toggle");
  endtask

  task automatic test_gnt_late();
    dump_and_check(8'hA0, 1'b0, 5, "gnt_late");
  endtask

  // Load 0x10+i; gap_mod>0 drops in_valid every gap_mod cycles; drop_at>0 removes gnt for 5 cycles.
  task automatic test_load(input int gap_mod, input int drop_at, input string tag);
    int c, next, writes, done_cyc;
    word_t w;
    for (int i = 0; i < int'(SIZE); i++) mem[i] = '0;
    exp_q.delete();
    for (int i = 0; i < int'(SIZE); i++) begin
      w.addr = AW'(i);
      w.data = 8'(8'h10 + 8'(i));
      exp_q.push_back(w);
    end
    next = 0; writes = 0; done_cyc = -1;
    start = 1'b1; mode = 1'b1; bus.rf_gnt = 1'b1; bus.out_ready = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h10;
    for (c = 0; c < 300 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (!bus.rf_gnt && c >= 1) begin
        total++;
        if (bus.in_ready !== 1'b0 || bus.rf_en !== 1'b0 || bus.rf_wr !== 1'b0 || bus.rf_req !== 1'b1)
          begin bad++; $display("FAIL %s gnt_gap c=%0d: rdy/en/wr/req got %b%b%b%b want 0001",
                                tag, c, bus.in_ready, bus.rf_en, bus.rf_wr, bus.rf_req); end
      end
      if (bus.rf_en === 1'b1 || bus.rf_wr === 1'b1) begin
        total++;
        if (!(bus.rf_en === 1'b1 && bus.rf_wr === 1'b1 && bus.in_valid && bus.in_ready === 1'b1))
          begin bad++; $display("FAIL %s wr_strobe c=%0d: en/wr/rdy got %b%b%b want 111", tag, c, bus.rf_en, bus.rf_wr, bus.in_ready); end
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL %s extra_write c=%0d: got %h want none", tag, c, {bus.rf_addr_write, bus.rf_data_write});
        end else begin
          w = exp_q.pop_front();
          if ({bus.rf_addr_write, bus.rf_data_write} !== w)
            begin bad++; $display("FAIL %s write c=%0d: got %h want %h", tag, c, {bus.rf_addr_write, bus.rf_data_write}, w); end
        end
        mem[bus.rf_addr_write] = bus.rf_data_write;
        writes++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        total++;
        if (bus.rf_wr !== 1'b1) begin bad++; $display("FAIL %s beat_no_write c=%0d: wr got %b want 1", tag, c, bus.rf_wr); end
        next++;
      end
      if (done === 1'b1) done_cyc = c;
      @(posedge clk); #1;
      start = 1'b0; mode = 1'b0;
      if (drop_at > 0) bus.rf_gnt = !((c + 1) >= drop_at && (c + 1) < drop_at + 5);
      bus.in_valid = (next < int'(SIZE)) && (gap_mod == 0 || ((c + 1) % gap_mod) != 0);
      bus.in_data  = 8'(8'h10 + 8'(next));
    end
    bus.in_valid = 1'b0; bus.rf_gnt = 1'b1;
    total++;
    if (done_cyc < 0) begin bad++; $display("FAIL %s timeout: done got never want pulse", tag); end
    total++;
    if (writes != int'(SIZE) || exp_q.size() != 0)
      begin bad++; $display("FAIL %s count: got %0d writes (%0d left) want %0d", tag, writes, exp_q.size(), SIZE); end
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL %s after_done: got %h want 0", tag, all_outs); end
    @(posedge clk); #1;
    dump_and_check(8'h10, 1'b0, 0, {tag, "_readback"});
  endtask

  task automatic test_reset_mid();
    bit found;
    for (int i = 0; i < int'(SIZE); i++) mem[i] = 8'(8'hA0 + 8'(i));
    start = 1'b1; mode = 1'b0; bus.rf_gnt = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_addr === AW'(1)) found = 1'b1;
      else begin @(posedge clk); #1; start = 1'b0; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL rst_mid reach_send_b: got none want addr 1 valid"); end
    rst = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL rst_mid in_reset: got %h want 0", all_outs); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL rst_mid idle: got %h want 0", all_outs); end
    @(posedge clk); #1;
    bus.rf_gnt = 1'b0; start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || bus.rf_req !== 1'b1 || bus.rf_en !== 1'b0)
      begin bad++; $display("FAIL rst_mid req_wait: busy/req/en got %b%b%b want 110", busy, bus.rf_req, bus.rf_en); end
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0; bus.rf_gnt = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (bus.rf_en !== 1'b1 || bus.rf_wr !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.rf_addr_read_1 !== AW'(0) || bus.rf_addr_read_2 !== AW'(1))
      begin bad++; $display("FAIL rst_mid start_ignored: en/wr/rdy %b%b%b addr %0d/%0d want 100 0/1",
                            bus.rf_en, bus.rf_wr, bus.in_ready, bus.rf_addr_read_1, bus.rf_addr_read_2); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dump_and_check(8'hA0, 1'b0, 0, "rst_restart");
  endtask

  initial begin
    test_reset();
    test_dump();
    test_ready_toggle();
    test_gnt_late();
    test_reset_mid();
    test_load(3, 0, "load_gaps");
    test_load(0, 8, "load_gnt_drop");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
endmodule
